// File: rtl/led_pattern_player.sv
// Pattern-ROM reader and LED driver: walks rom_addr from start_addr to end_addr and wraps.
// Each ROM word stays on the LEDs for STEP_CYCLES clocks. A change of range restarts the sequence.
module led_pattern_player #(
    parameter int ADDR_W      = 5,
    parameter int LED_W       = 8,
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LED_W-1:0]  rom_data,
    output logic [LED_W-1:0]  led,
    output logic              wrap_pulse
);

    localparam int                TICK_W    = $clog2(STEP_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 3);
    localparam logic [ADDR_W-1:0] ADDR_ONES = '1;

    typedef enum logic [1:0] {
        RESTART = 2'd0,
        FETCH   = 2'd1,
        SHOW    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic                wrap_q, wrap_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [ADDR_W-1:0]   cur_start_q, cur_start_d;
    logic [ADDR_W-1:0]   cur_end_q, cur_end_d;
    logic                range_changed;

    assign range_changed = (start_addr != cur_start_q) || (end_addr != cur_end_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESTART;
            rom_addr_q  <= '0;
            led_q       <= '0;
            wrap_q      <= 1'b0;
            tick_q      <= '0;
            cur_start_q <= '0;
            cur_end_q   <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            led_q       <= led_d;
            wrap_q      <= wrap_d;
            tick_q      <= tick_d;
            cur_start_q <= cur_start_d;
            cur_end_q   <= cur_end_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        led_d       = led_q;
        wrap_d      = 1'b0;
        tick_d      = tick_q;
        cur_start_d = cur_start_q;
        cur_end_d   = cur_end_q;

        case (state_q)
            RESTART: begin
                cur_start_d = start_addr;
                cur_end_d   = end_addr;
                rom_addr_d  = start_addr;
                state_d     = FETCH;
            end
            FETCH: begin
                state_d = SHOW;
            end
            SHOW: begin
                led_d   = rom_data;
                tick_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_LAST) begin
                    // The all-ones test keeps the increment from overflowing to zero.
                    if ((rom_addr_q >= cur_end_q) || (rom_addr_q == ADDR_ONES)) begin
                        rom_addr_d = cur_start_q;
                        wrap_d     = 1'b1;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                    end
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = RESTART;
            end
        endcase

        // A new range overrides any advance, display update or wrap in this cycle.
        if ((state_q != RESTART) && range_changed) begin
            state_d    = RESTART;
            rom_addr_d = rom_addr_q;
            led_d      = led_q;
            wrap_d     = 1'b0;
            tick_d     = tick_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign led        = led_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// Directed bench for led_pattern_player with STEP_CYCLES=4 and a 1-clock registered ROM model.
module tb_led_pattern_player;

    logic       clk;
    logic       rst;
    logic [4:0] start_addr;
    logic [4:0] end_addr;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] led;
    logic       wrap_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    led_pattern_player #(
        .ADDR_W     (5),
        .LED_W      (8),
        .STEP_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .led       (led),
        .wrap_pulse(wrap_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-output pattern ROM: data = addr + 0x10.
    always_ff @(posedge clk) begin
        rom_data <= {3'b000, rom_addr} + 8'h10;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] s, input logic [4:0] e);
        start_addr = s;
        end_addr   = e;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        #1;

        // Range 0..4
        do_reset(5'd0, 5'd4);
        check("t1_reset_led", 32'(led), 32'h00);
        check("t1_reset_addr", 32'(rom_addr), 32'h00);
        check("t1_reset_wrap", 32'(wrap_pulse), 32'h0);
        step(2);
        check("t1_led_e2", 32'(led), 32'h00);
        step(1);
        check("t1_led_e3", 32'(led), 32'h10);
        for (int i = 1; i <= 4; i++) begin
            step(4);
            check("t1_led_step", 32'(led), 32'(8'h10 + i));
        end
        check("t1_wrap_e19", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t1_wrap_e20", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t1_wrap_e21", 32'(wrap_pulse), 32'h1);
        check("t1_addr_e21", 32'(rom_addr), 32'h00);
        step(1);
        check("t1_wrap_e22", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t1_led_e23", 32'(led), 32'h10);

        // Range 5..9, then switched to 10..17 while led shows 0x16
        do_reset(5'd5, 5'd9);
        step(3);
        check("t2_led_e3", 32'(led), 32'h15);
        step(4);
        check("t2_led_e7", 32'(led), 32'h16);
        start_addr = 5'd10;
        end_addr   = 5'd17;
        step(1);
        check("t2_addr_e8", 32'(rom_addr), 32'd6);
        check("t2_led_e8", 32'(led), 32'h16);
        check("t2_wrap_e8", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t2_addr_e9", 32'(rom_addr), 32'd10);
        check("t2_led_e9", 32'(led), 32'h16);
        check("t2_wrap_e9", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t2_led_e10", 32'(led), 32'h16);
        check("t2_wrap_e10", 32'(wrap_pulse), 32'h0);
        step(1);
        check("t2_led_e11", 32'(led), 32'h1A);
        check("t2_wrap_e11", 32'(wrap_pulse), 32'h0);

        // start == end == 18
        do_reset(5'd18, 5'd18);
        for (int n = 1; n <= 14; n++) begin
            step(1);
            check("t3_addr", 32'(rom_addr), 32'd18);
            if (n >= 3) check("t3_led", 32'(led), 32'h22);
            check("t3_wrap", 32'(wrap_pulse), 32'((n >= 5) && (((n - 5) % 4) == 0)));
        end

        // end < start: single step at 20
        do_reset(5'd20, 5'd3);
        for (int n = 1; n <= 14; n++) begin
            step(1);
            check("t4_addr", 32'(rom_addr), 32'd20);
            if (n >= 3) check("t4_led", 32'(led), 32'h24);
            check("t4_wrap", 32'(wrap_pulse), 32'((n >= 5) && (((n - 5) % 4) == 0)));
        end

        // Range 18..25, asynchronous reset mid-HOLD at address 21
        do_reset(5'd18, 5'd25);
        step(15);
        check("t5_led_e15", 32'(led), 32'h25);
        check("t5_addr_e15", 32'(rom_addr), 32'd21);
        rst = 1'b1;
        #1;
        check("t5_async_led", 32'(led), 32'h00);
        check("t5_async_addr", 32'(rom_addr), 32'h00);
        check("t5_async_wrap", 32'(wrap_pulse), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);
        check("t5_led_e2", 32'(led), 32'h00);
        step(1);
        check("t5_led_e3", 32'(led), 32'h22);

        // Range 30..31: all-ones end must wrap to 30, never to 0
        do_reset(5'd30, 5'd31);
        for (int n = 1; n <= 16; n++) begin
            step(1);
            check("t6_addr", 32'(rom_addr), ((((n - 1) / 4) % 2) == 1) ? 32'd31 : 32'd30);
            check("t6_wrap", 32'(wrap_pulse), 32'(n == 9));
            if (n == 3 || n == 11) check("t6_led_30", 32'(led), 32'h2E);
            if (n == 7 || n == 15) check("t6_led_31", 32'(led), 32'h2F);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
